i2c_regfile_ctrl: RTL
=====================

// Module: i2c_regfile_ctrl
// PURPOSE
//  Sequencer between the i2c_slave device interface and an 8-bit register bank.
//  Holds a register pointer; the first written byte of a write transfer loads it.
//  Later written bytes become bank writes with pointer auto-increment.
//  Read transfers are served from a one-byte prefetch buffer, so txbyte_o is valid before each dequeue.
//  Bank access uses a req/ack handshake that tolerates multi-cycle slaves.
// PARAMETERS
//  AW       4      register address width; the bank has 2^AW bytes; the pointer wraps modulo 2^AW
//  TX_FILL  8'hFF  byte presented on txbyte_o while no valid read data is held
// PORTS
//  clk6x        in   1   system clock, 48MHz
//  resetn       in   1   synchronous reset, active low
//  devsel_i     in   1   i2c_slave devsel_o: our address is selected
//  rw_bit_i     in   1   i2c_slave rw_bit_o: 1=master read, 0=master write
//  rxbyte_i     in   8   i2c_slave rxbyte_o
//  rxbyte_v_i   in   1   i2c_slave rxbyte_v_o, 1T strobe
//  txbyte_o     out  8   to i2c_slave txbyte_i
//  txbyte_deq_i in   1   i2c_slave txbyte_deq_o, 1T strobe
//  tx_nacked_i  in   1   i2c_slave tx_nacked_o, 1T strobe
//  reg_addr_o   out  AW  bank address
//  reg_wdata_o  out  8   bank write data
//  reg_wr_o     out  1   write request, held until ack
//  reg_rd_o     out  1   read request, held until ack
//  reg_rdata_i  in   8   bank read data, sampled when reg_ack_i=1
//  reg_ack_i    in   1   access done; sampled only while reg_wr_o or reg_rd_o is 1
//  ovf_o        out  1   1T pulse: write overrun or read underrun
//  busy_o       out  1   1 when any state other than IDLE
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, ptr=0, txbyte_o=TX_FILL.
//   - reg_wr_o=0, reg_rd_o=0, reg_addr_o=0, reg_wdata_o=0, ovf_o=0.
//  Edge detection: devsel rise/fall is taken from devsel_i registered by 1T.
//  The pointer is kept across transfers, so a repeated-start read continues from the address that was written.
//  Bus handshake:
//   - reg_addr_o and reg_wdata_o stay stable while a strobe is 1.
//   - The strobe drops in the cycle after reg_ack_i=1.
//   - Minimum access time is 2T.
//   - reg_wr_o and reg_rd_o are never 1 together.
//  States:
//   - IDLE: on devsel rise with rw=0 -> W_ADDR; with rw=1 -> R_FETCH.
//   - W_ADDR: on rxbyte_v_i, ptr <= rxbyte_i[AW-1:0] (upper bits ignored) -> W_DATA.
//   - W_DATA: on rxbyte_v_i, reg_wr_o=1, addr=ptr, wdata=rxbyte_i -> W_BUS.
//   - W_BUS: on ack, ptr <= ptr+1 (wraps) -> W_DATA.
//       rxbyte_v_i in this state: byte dropped, ovf_o pulses 1T, ptr not advanced.
//   - R_FETCH: txbyte_o <= TX_FILL, reg_rd_o=1, addr=ptr -> R_BUS.
//   - R_BUS: on ack, txbyte_o <= reg_rdata_i -> R_HOLD.
//       txbyte_deq_i in this state: underrun. The master has already got TX_FILL.
//       ovf_o pulses 1T; ptr <= ptr+1.
//       When ack arrives, the fetched data is discarded and the FSM goes -> R_FETCH.
//   - R_HOLD: on txbyte_deq_i, ptr <= ptr+1 -> R_FETCH (prefetch of the next byte).
//       tx_nacked_i: no state change; ptr is already past the last delivered byte.
//  Prefetch side effect: the bank sees one extra read beyond the last byte the master NACKs.
//   Bank reads must therefore be side-effect free.
//  devsel fall (stop, restart, or address mismatch):
//   - In W_BUS or R_BUS: the strobe stays asserted until ack.
//       A pending write completes and still increments ptr.
//       A pending read result is discarded.
//   - Then -> IDLE.
//   - From any other state -> IDLE immediately.
//   - txbyte_o is left unchanged.
//  devsel fall and rise in consecutive cycles are handled as fall, then rise.
//   The new transfer starts only after IDLE is reached.
//  Simultaneous strobes in one cycle: ack and rxbyte_v_i in W_BUS counts as overrun.
//   The byte is dropped even though the access completes in that same cycle.
//  resetn=0 mid-access: strobes drop on the next edge. No completion is guaranteed.
// TESTING
//  1. Write 0x03,0xAA,0xBB with a 1T-ack bank.
//     -> bank[3]=AA, bank[4]=BB, ptr=5, ovf_o never 1.
//  2. Write ptr 0x0F (AW=4), then data 0x11,0x22.
//     -> bank[15]=11, bank[0]=22 (wrap), ptr=1.
//  3. Write ptr 0x02, restart, read 3 bytes with bank[2..5]=10,20,30,40 and NACK on byte 3.
//     -> master gets 10,20,30; reads of addr 2,3,4,5 were issued; ptr=5.
//  4. Hold ack 20T and send a second rxbyte_v_i during W_BUS.
//     -> first byte written, second dropped, ovf_o one 1T pulse.
//  5. Hold read ack 40T; dequeue before ack.
//     -> txbyte_o=FF when dequeued, ovf_o pulse, next fetch from ptr+1.
//  6. Drop devsel while reg_wr_o=1 and ack is delayed 5T.
//     -> reg_wr_o stays 1 until ack, ptr increments, then IDLE with busy_o=0.

Source files
------------

// File: rtl/i2c_regfile_ctrl.sv
// Register-file sequencer behind an I2C slave: pointer load, auto-increment writes,
// prefetched reads, and a req/ack bank bus that tolerates slow slaves.
module i2c_regfile_ctrl #(
    parameter int unsigned AW      = 4,
    parameter logic [7:0]  TX_FILL = 8'hFF
) (
    input  logic          clk6x,
    input  logic          resetn,
    input  logic          devsel_i,
    input  logic          rw_bit_i,
    input  logic [7:0]    rxbyte_i,
    input  logic          rxbyte_v_i,
    output logic [7:0]    txbyte_o,
    input  logic          txbyte_deq_i,
    input  logic          tx_nacked_i,
    output logic [AW-1:0] reg_addr_o,
    output logic [7:0]    reg_wdata_o,
    output logic          reg_wr_o,
    output logic          reg_rd_o,
    input  logic [7:0]    reg_rdata_i,
    input  logic          reg_ack_i,
    output logic          ovf_o,
    output logic          busy_o
);

    typedef enum logic [2:0] {
        StIdle, StWAddr, StWData, StWBus, StRFetch, StRBus, StRHold
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d, addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d, tx_q, tx_d;
    logic          wr_q, wr_d, rd_q, rd_d, ovf_q, ovf_d;
    logic          devsel_q, abort_q, abort_d, pend_q, pend_d, drop_q, drop_d;
    logic          rise, fall;

    // NACK needs no action: the pointer already sits past the last delivered byte.
    logic unused_nack;
    assign unused_nack = tx_nacked_i;

    assign rise = devsel_i & ~devsel_q;
    assign fall = ~devsel_i & devsel_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tx_d    = tx_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        ovf_d   = 1'b0;
        abort_d = abort_q;
        drop_d  = drop_q;
        // A rise seen while still finishing an aborted access starts the next transfer later.
        pend_d  = pend_q;
        if (fall) begin
            pend_d = 1'b0;
        end else if (rise && state_q != StIdle) begin
            pend_d = 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                abort_d = 1'b0;
                drop_d  = 1'b0;
                if (devsel_i && (rise || pend_q)) begin
                    pend_d  = 1'b0;
                    state_d = rw_bit_i ? StRFetch : StWAddr;
                end
            end
            StWAddr: begin
                if (fall) begin
                    state_d = StIdle;
                end else if (rxbyte_v_i) begin
                    ptr_d   = rxbyte_i[AW-1:0];
                    state_d = StWData;
                end
            end
            StWData: begin
                if (fall) begin
                    state_d = StIdle;
                end else if (rxbyte_v_i) begin
                    wr_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = rxbyte_i;
                    state_d = StWBus;
                end
            end
            StWBus: begin
                if (fall) abort_d = 1'b1;
                if (rxbyte_v_i) ovf_d = 1'b1;
                if (reg_ack_i) begin
                    wr_d    = 1'b0;
                    ptr_d   = ptr_q + AW'(1);
                    state_d = (abort_q || fall) ? StIdle : StWData;
                end
            end
            StRFetch: begin
                if (fall) begin
                    state_d = StIdle;
                end else begin
                    tx_d    = TX_FILL;
                    rd_d    = 1'b1;
                    addr_d  = ptr_q;
                    state_d = StRBus;
                end
            end
            StRBus: begin
                if (fall) abort_d = 1'b1;
                if (txbyte_deq_i) begin
                    ovf_d  = 1'b1;
                    ptr_d  = ptr_q + AW'(1);
                    drop_d = 1'b1;
                end
                if (reg_ack_i) begin
                    rd_d   = 1'b0;
                    drop_d = 1'b0;
                    if (abort_q || fall) begin
                        state_d = StIdle;
                    end else if (drop_q || txbyte_deq_i) begin
                        state_d = StRFetch;
                    end else begin
                        tx_d    = reg_rdata_i;
                        state_d = StRHold;
                    end
                end
            end
            StRHold: begin
                if (fall) begin
                    state_d = StIdle;
                end else if (txbyte_deq_i) begin
                    ptr_d   = ptr_q + AW'(1);
                    state_d = StRFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            tx_q     <= TX_FILL;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            ovf_q    <= 1'b0;
            devsel_q <= 1'b0;
            abort_q  <= 1'b0;
            pend_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            tx_q     <= tx_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            ovf_q    <= ovf_d;
            devsel_q <= devsel_i;
            abort_q  <= abort_d;
            pend_q   <= pend_d;
            drop_q   <= drop_d;
        end
    end

    assign txbyte_o    = tx_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_wr_o    = wr_q;
    assign reg_rd_o    = rd_q;
    assign ovf_o       = ovf_q;
    assign busy_o      = (state_q != StIdle);

endmodule
